reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences board bring-up after the debounced reset: pulses the PLL reset, waits for lock with timeout and bounded retry, qualifies lock stability, then releases N downstream domain resets one at a time in a fixed order. Sits between the reset debouncer and all synchronous logic. On lock loss it re-asserts every domain reset and restarts the sequence. Reports `ready`, `fault` and the retry count.

## Interface
- `N_DOMAINS`, 4: number of sequenced domain resets, range 1..16.
- `PLL_RST_CYCLES`, 4: `pll_rst` pulse width in clocks, at least 1.
- `LOCK_TIMEOUT`, 1024: clocks allowed in WAIT_LOCK before a timeout.
- `STAGE_DELAY`, 16: lock-qualify window, and spacing between domain releases, in clocks; at least 1.
- `MAX_RETRIES`, 3: timeouts tolerated before FAULT.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_rst`, in, 1: synchronous restart request, one-cycle pulse or level.
- `pll_locked`, in, 1: asynchronous; synchronized internally by a 2-flop synchronizer whose flops reset to 0.
- `pll_rst`, out, 1: PLL reset, active-high, registered.
- `domain_rst`, out, N_DOMAINS: domain resets, active-high, registered; bit 0 is released first.
- `ready`, out, 1: all domains released, in RUN.
- `fault`, out, 1: retries exhausted; sticky until `req_rst`.
- `retry_cnt`, out, $clog2(MAX_RETRIES+1): timeouts since the last `rst_n` or `req_rst`.

## Operation
- **States:** PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
- **Reset values:** state PLL_RESET; `pll_rst`=1; `domain_rst`=all ones; `ready`=0; `fault`=0; `retry_cnt`=0; counters and domain index 0.
- **PLL_RESET:** `pll_rst`=1 and all `domain_rst`=1. Moves to WAIT_LOCK after exactly PLL_RST_CYCLES cycles; `pll_rst` falls on that edge.
- **WAIT_LOCK:**
  - If `lock_s` (synchronized lock) is 1, go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment `retry_cnt`, which saturates.
  - If the new count equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RESET.
- **STABLE:** requires `lock_s`=1 for STAGE_DELAY consecutive cycles, then goes to RELEASE. Any 0 returns to WAIT_LOCK with the timeout counter cleared; this does not count as a retry.
- **RELEASE:**
  - The counter runs 0..STAGE_DELAY-1. At STAGE_DELAY-1, clear `domain_rst[idx]`, increment `idx` and clear the counter.
  - Clearing bit N_DOMAINS-1 enters RUN, and `ready` rises on the same edge.
  - Released bits stay 0.
- **RUN:** hold. `retry_cnt` is not cleared.
- **Lock loss:** `lock_s`=0 in RELEASE or RUN goes to PLL_RESET. All `domain_rst` return to 1 and `ready` to 0 on the same edge. `retry_cnt` is unchanged.
- **FAULT:** `fault`=1, `pll_rst`=1, all `domain_rst`=1. Only `req_rst` exits.
- **`req_rst`:** in any state, goes to PLL_RESET on the next edge, clears `retry_cnt`, `fault` and `ready`, and sets all `domain_rst`. It has priority over lock loss and timeout in the same cycle.
- **`rst_n` assertion** at any time, including mid-release, forces the reset values asynchronously.

## Timing
- All outputs are registered and change only on `clk` rising edges, except on asynchronous `rst_n` assertion.
- `pll_locked` to `lock_s` latency: 2 cycles.
- State occupancy:
  - PLL_RESET: PLL_RST_CYCLES.
  - WAIT_LOCK: at least 1 cycle.
  - STABLE: STAGE_DELAY cycles.
  - RELEASE: N_DOMAINS × STAGE_DELAY cycles.
- `domain_rst[i]` falls (i+1)·STAGE_DELAY cycles after RELEASE entry.
- With lock already stable, `ready` rises PLL_RST_CYCLES + 1 + STAGE_DELAY + N_DOMAINS·STAGE_DELAY cycles after the first edge following `rst_n` release.
- Lock-loss response: edge N+2 after `pll_locked` falls (synchronizer latency).

## Configuration
- **`RESET_SEQUENCER_RETRY_EN` defined:** timeouts retry as above, up to MAX_RETRIES.
- **Not defined:**
  - The first timeout goes directly to FAULT.
  - `retry_cnt` is tied to 0.
  - MAX_RETRIES is ignored.

## Test plan
Parameters: N_DOMAINS=4, PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, STAGE_DELAY=8, MAX_RETRIES=3, with `RESET_SEQUENCER_RETRY_EN` defined.
- **Nominal bring-up:** `pll_locked`=1 from time 0, release `rst_n` -> `pll_rst` high for 4 cycles; `domain_rst` falls 0001b…1111b cleared at 8-cycle spacing; `ready` at cycle 45; `retry_cnt`=0.
- **Timeout retries:** `pll_locked`=0 always -> three `pll_rst` pulses 68 cycles apart; `retry_cnt` 1, 2, 3; `fault`=1 after the third timeout; `domain_rst`=1111b throughout.
- **STABLE glitch:** drop `pll_locked` for 1 cycle on the 5th cycle of STABLE -> return to WAIT_LOCK; `retry_cnt` unchanged; `ready` delayed by the re-qualify time.
- **Lock loss in RUN:** drop `pll_locked` -> 2 cycles later `domain_rst`=1111b, `ready`=0, `pll_rst` pulses for 4 cycles; the full sequence repeats.
- **Restart out of FAULT and mid-release:**
  - `req_rst` while in FAULT -> `fault`=0 and `retry_cnt`=0 next edge; bring-up resumes.
  - `req_rst` during RELEASE with 2 domains already released -> all `domain_rst` back to 1 next edge.
- **Asynchronous reset mid-release:** assert `rst_n` low between clock edges during RELEASE -> outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset sequencer: PLL reset pulse, lock wait with timeout/retry, lock
// qualification, then ordered domain release. Optional retry: RESET_SEQUENCER_RETRY_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// PLL_RESET   | pll_rst high for PLL_RST_CYCLES, all domains held
// WAIT_LOCK   | wait for synchronized lock, count toward LOCK_TIMEOUT
// STABLE      | lock must stay high STAGE_DELAY consecutive cycles
// RELEASE     | drop one domain reset every STAGE_DELAY cycles, bit 0 first
// RUN         | all domains released, ready high
// FAULT       | retries exhausted, everything held until req_rst
module reset_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int STAGE_DELAY    = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_rst,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic [N_DOMAINS-1:0]               domain_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int CNT_MAX = (LOCK_TIMEOUT > STAGE_DELAY) ?
                           ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES) :
                           ((STAGE_DELAY > PLL_RST_CYCLES) ? STAGE_DELAY : PLL_RST_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SD_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       sync;
  logic             lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pll_locked};
  end

  assign lock_s = sync[1];

`ifdef RESET_SEQUENCER_RETRY_EN
  logic [RC_W-1:0] retry_q;
  logic [RC_W-1:0] retry_next;

  // Saturate so a large MAX_RETRIES never wraps the reported count.
  assign retry_next = (retry_q == {RC_W{1'b1}}) ? retry_q : retry_q + 1'b1;
  assign retry_cnt  = retry_q;
`else
  assign retry_cnt  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PLL_RESET;
      cnt        <= '0;
      idx        <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
      fault      <= 1'b0;
`ifdef RESET_SEQUENCER_RETRY_EN
      retry_q    <= '0;
`endif
    end else if (req_rst) begin
      state      <= S_PLL_RESET;
      cnt        <= '0;
      idx        <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
      fault      <= 1'b0;
`ifdef RESET_SEQUENCER_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      case (state)
        S_PLL_RESET: begin
          if (cnt == PLL_LAST) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
`ifdef RESET_SEQUENCER_RETRY_EN
            retry_q <= retry_next;
            if (retry_next == RC_W'(MAX_RETRIES)) begin
              state <= S_FAULT;
              fault <= 1'b1;
            end else begin
              state <= S_PLL_RESET;
            end
`else
            state <= S_FAULT;
            fault <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          // A dropout restarts the lock wait but is not a timeout.
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == SD_LAST) begin
            state <= S_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (!lock_s) begin
            state      <= S_PLL_RESET;
            cnt        <= '0;
            idx        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
          end else if (cnt == SD_LAST) begin
            cnt             <= '0;
            domain_rst[idx] <= 1'b0;
            if (idx == IDX_LAST) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state      <= S_PLL_RESET;
            cnt        <= '0;
            idx        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
          end
        end

        S_FAULT: begin
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          fault      <= 1'b1;
        end

        default: begin
          state      <= S_PLL_RESET;
          cnt        <= '0;
          idx        <= '0;
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output-change
// events (edge number + value), a monitor pops one per observed output change.
module tb_reset_sequencer;

  localparam int SD   = 8;
  localparam int RC_W = 2;
  localparam logic [3:0] F = 4'hF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_rst;
  logic            pll_locked;
  logic            pll_rst;
  logic [3:0]      domain_rst;
  logic            ready;
  logic            fault;
  logic [RC_W-1:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  exp_t sbq[$];

  reset_sequencer #(
    .N_DOMAINS     (4),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (64),
    .STAGE_DELAY   (SD),
    .MAX_RETRIES   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_rst   (req_rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .domain_rst(domain_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wire [8:0] outs = {pll_rst, domain_rst, ready, fault, retry_cnt};

  function automatic logic [8:0] ov(logic p, logic [3:0] dm, logic r, logic f, logic [1:0] c);
    return {p, dm, r, f, c};
  endfunction

  task automatic push(input int c, input logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    sbq.push_back(e);
  endtask

  // Domain release events after STABLE is entered at edge st (first n of them).
  task automatic exp_release(input int st, input logic [1:0] rc, input int n);
    logic [3:0] dm;
    for (int i = 0; i < n; i++) begin
      dm = F;
      dm = dm << (i + 1);
      push(st + SD + SD * (i + 1), ov(1'b0, dm, (i == 3), 1'b0, rc));
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic async_reset();
    push(cyc, ov(1'b1, F, 1'b0, 1'b0, 2'd0));
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [8:0] prev;
    exp_t       e;
    @(negedge clk);
    #1;
    checks++;
    if (outs !== ov(1'b1, F, 1'b0, 1'b0, 2'd0)) begin
      errors++;
      $display("FAIL reset_state got %b want %b", outs, ov(1'b1, F, 1'b0, 1'b0, 2'd0));
    end
    prev = outs;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (outs !== prev) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change at edge %0d got %b", cyc, outs);
        end else begin
          e = sbq.pop_front();
          if (outs !== e.v || cyc != e.cyc) begin
            errors++;
            $display("FAIL output_event got %b at edge %0d want %b at edge %0d",
                     outs, cyc, e.v, e.cyc);
          end
        end
        prev = outs;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired at edge %0d with %0d events pending", cyc, sbq.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dl;
    int fault_c;

    rst_n      = 1'b1;
    req_rst    = 1'b0;
    pll_locked = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal bring-up: ready on the 45th edge after release.
    base  = cyc;
    rst_n = 1'b1;
    push(base + 4, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    exp_release(base + 5, 2'd0, 4);
    wait_cyc(base + 50);

    // Lock loss in RUN: response two edges after the first capturing edge.
    dl = cyc;
    pll_locked = 1'b0;
    push(dl + 3, ov(1'b1, F, 1'b0, 1'b0, 2'd0));
    wait_cyc(dl + 2);
    pll_locked = 1'b1;
    push(dl + 7, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    exp_release(dl + 8, 2'd0, 4);
    wait_cyc(dl + 55);

    // One-cycle lock glitch during STABLE delays release by the re-qualify time.
    async_reset();
    base  = cyc;
    rst_n = 1'b1;
    push(base + 4, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    wait_cyc(base + 7);
    pll_locked = 1'b0;
    wait_cyc(base + 8);
    pll_locked = 1'b1;
    exp_release(base + 11, 2'd0, 4);
    wait_cyc(base + 60);

    // req_rst with two domains released.
    async_reset();
    base  = cyc;
    rst_n = 1'b1;
    push(base + 4, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    exp_release(base + 5, 2'd0, 2);
    wait_cyc(base + 31);
    push(base + 32, ov(1'b1, F, 1'b0, 1'b0, 2'd0));
    req_rst = 1'b1;
    wait_cyc(base + 32);
    req_rst = 1'b0;
    push(base + 36, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    exp_release(base + 37, 2'd0, 4);
    wait_cyc(base + 85);

    // Lock never arrives: timeouts 68 edges apart, then FAULT.
    pll_locked = 1'b0;
    async_reset();
    base  = cyc;
    rst_n = 1'b1;
    push(base + 4, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
`ifdef RESET_SEQUENCER_RETRY_EN
    push(base + 68,  ov(1'b1, F, 1'b0, 1'b0, 2'd1));
    push(base + 72,  ov(1'b0, F, 1'b0, 1'b0, 2'd1));
    push(base + 136, ov(1'b1, F, 1'b0, 1'b0, 2'd2));
    push(base + 140, ov(1'b0, F, 1'b0, 1'b0, 2'd2));
    push(base + 204, ov(1'b1, F, 1'b0, 1'b1, 2'd3));
    fault_c = base + 204;
`else
    push(base + 68, ov(1'b1, F, 1'b0, 1'b1, 2'd0));
    fault_c = base + 68;
`endif
    wait_cyc(fault_c + 10);
    pll_locked = 1'b1;
    wait_cyc(fault_c + 16);
    push(fault_c + 17, ov(1'b1, F, 1'b0, 1'b0, 2'd0));
    req_rst = 1'b1;
    wait_cyc(fault_c + 17);
    req_rst = 1'b0;
    push(fault_c + 21, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    exp_release(fault_c + 22, 2'd0, 2);

    // Asynchronous reset between edges mid-release.
    wait_cyc(fault_c + 48);
    async_reset();
    base  = cyc;
    rst_n = 1'b1;
    push(base + 4, ov(1'b0, F, 1'b0, 1'b0, 2'd0));
    wait_cyc(base + 8);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d left want 0 (next at edge %0d)", sbq.size(), sbq[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
